// File: rtl/pipelined_addsub_if.sv
// Operand/result handshake bundle for pipelined_addsub.
// master drives operands and out_ready; slave is the adder pipeline.
interface pipelined_addsub_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             overflow;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, overflow, zero, negative
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one WIDTH/STAGES-bit carry chunk
// per register stage, whole-pipe stall on output backpressure.
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipelined_addsub_if.slave bus
);
  localparam int C = WIDTH / STAGES;

  // acc holds finished low result chunks with the not-yet-added upper bits of a
  // in place; b_eff stays in place, so both sign bits survive until the last stage.
  logic             vld_q   [STAGES];
  logic             vld_d   [STAGES];
  logic [WIDTH-1:0] acc_q   [STAGES];
  logic [WIDTH-1:0] acc_d   [STAGES];
  logic [WIDTH-1:0] opb_q   [STAGES];
  logic [WIDTH-1:0] opb_d   [STAGES];
  logic             cy_q    [STAGES];
  logic             cy_d    [STAGES];

  logic             src_vld [STAGES];
  logic [WIDTH-1:0] src_acc [STAGES];
  logic [WIDTH-1:0] src_opb [STAGES];
  logic             src_cy  [STAGES];

  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             adv;
  logic [WIDTH-1:0] b_eff;
  logic [C:0]       chunk_sum;

  assign adv   = !vld_q[STAGES-1] || bus.out_ready;
  assign b_eff = bus.b ^ {WIDTH{bus.sub}};

  always_comb begin
    src_vld[0] = bus.in_valid;
    src_acc[0] = bus.a;
    src_opb[0] = b_eff;
    src_cy[0]  = bus.sub;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_q[k-1];
      src_acc[k] = acc_q[k-1];
      src_opb[k] = opb_q[k-1];
      src_cy[k]  = cy_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      vld_d[k] = vld_q[k];
      acc_d[k] = acc_q[k];
      opb_d[k] = opb_q[k];
      cy_d[k]  = cy_q[k];
    end
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    chunk_sum = '0;
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        chunk_sum = {1'b0, src_acc[k][k*C +: C]} + {1'b0, src_opb[k][k*C +: C]}
                  + {{C{1'b0}}, src_cy[k]};
        vld_d[k] = src_vld[k];
        // Bubbles leave stage data untouched so outputs keep their last value.
        if (src_vld[k]) begin
          acc_d[k]             = src_acc[k];
          acc_d[k][k*C +: C]   = chunk_sum[C-1:0];
          opb_d[k]             = src_opb[k];
          cy_d[k]              = chunk_sum[C];
        end
      end
      if (src_vld[STAGES-1]) begin
        ovf_d  = (src_acc[STAGES-1][WIDTH-1] == src_opb[STAGES-1][WIDTH-1])
              && (acc_d[STAGES-1][WIDTH-1] != src_acc[STAGES-1][WIDTH-1]);
        zero_d = (acc_d[STAGES-1] == '0);
        neg_d  = acc_d[STAGES-1][WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= 1'b0;
        acc_q[k] <= '0;
        opb_q[k] <= '0;
        cy_q[k]  <= 1'b0;
      end
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k] <= vld_d[k];
        acc_q[k] <= acc_d[k];
        opb_q[k] <= opb_d[k];
        cy_q[k]  <= cy_d[k];
      end
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.result    = acc_q[STAGES-1];
  assign bus.cout      = cy_q[STAGES-1];
  assign bus.overflow  = ovf_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = neg_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed table, latency/throughput/reset sequences,
// and randomized backpressure runs on three parameter sets against an arithmetic model.
module tb_pipelined_addsub;
  localparam int ND = 3;
  localparam int WID [ND] = '{64, 8, 32};

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic        drv_iv   [ND];
  logic        drv_ordy [ND];
  logic        drv_sub  [ND];
  logic [63:0] drv_a    [ND];
  logic [63:0] drv_b    [ND];
  logic        m_ov     [ND];
  logic        m_irdy   [ND];
  logic [67:0] m_out    [ND];

  logic [67:0] sb [ND][64];
  int          head [ND];
  int          tail [ND];
  int          n_in [ND];
  int          n_out [ND];
  logic [67:0] prev [ND];
  logic        prev_stall [ND];

  pipelined_addsub_if #(.WIDTH(64)) bus64 ();
  pipelined_addsub_if #(.WIDTH(8))  bus8 ();
  pipelined_addsub_if #(.WIDTH(32)) bus32 ();

  pipelined_addsub #(.WIDTH(64), .STAGES(4)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(bus64));
  pipelined_addsub #(.WIDTH(8),  .STAGES(1)) u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  pipelined_addsub #(.WIDTH(32), .STAGES(8)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  assign bus64.in_valid  = drv_iv[0];
  assign bus64.out_ready = drv_ordy[0];
  assign bus64.sub       = drv_sub[0];
  assign bus64.a         = drv_a[0];
  assign bus64.b         = drv_b[0];
  assign bus8.in_valid   = drv_iv[1];
  assign bus8.out_ready  = drv_ordy[1];
  assign bus8.sub        = drv_sub[1];
  assign bus8.a          = drv_a[1][7:0];
  assign bus8.b          = drv_b[1][7:0];
  assign bus32.in_valid  = drv_iv[2];
  assign bus32.out_ready = drv_ordy[2];
  assign bus32.sub       = drv_sub[2];
  assign bus32.a         = drv_a[2][31:0];
  assign bus32.b         = drv_b[2][31:0];

  assign m_ov[0]   = bus64.out_valid;
  assign m_ov[1]   = bus8.out_valid;
  assign m_ov[2]   = bus32.out_valid;
  assign m_irdy[0] = bus64.in_ready;
  assign m_irdy[1] = bus8.in_ready;
  assign m_irdy[2] = bus32.in_ready;
  assign m_out[0]  = {bus64.result, bus64.cout, bus64.overflow, bus64.zero, bus64.negative};
  assign m_out[1]  = {56'd0, bus8.result, bus8.cout, bus8.overflow, bus8.zero, bus8.negative};
  assign m_out[2]  = {32'd0, bus32.result, bus32.cout, bus32.overflow, bus32.zero, bus32.negative};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Reference: unsigned arithmetic for result/carry, exact signed arithmetic for overflow.
  function automatic logic [67:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                         input logic s);
    logic [64:0]        mask, ua, ub, full;
    logic [63:0]        res;
    logic signed [66:0] sa, sb, tr, lim;
    logic               co, ov;
    mask = (65'd1 << w) - 65'd1;
    ua   = {1'b0, a} & mask;
    ub   = {1'b0, b} & mask;
    if (s) begin
      full = ua - ub;
      co   = (ua >= ub);
    end else begin
      full = ua + ub;
      co   = full[w];
    end
    res = full[63:0] & mask[63:0];
    lim = 67'sd1 <<< (w - 1);
    sa  = $signed({2'b00, ua});
    sb  = $signed({2'b00, ub});
    if (a[w-1]) sa = sa - (lim <<< 1);
    if (b[w-1]) sb = sb - (lim <<< 1);
    tr  = s ? (sa - sb) : (sa + sb);
    ov  = (tr >= lim) || (tr < -lim);
    return {res, co, ov, (res == 64'd0), res[w-1]};
  endfunction

  function automatic logic [63:0] pick();
    logic [63:0] corner [4];
    corner[0] = 64'd0;
    corner[1] = '1;
    corner[2] = 64'h8000_0000_8000_8080;
    corner[3] = 64'h7FFF_FFFF_7FFF_7F7F;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return {$urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (!rst_n) begin
        head[d]       = 0;
        tail[d]       = 0;
        prev[d]       = '0;
        prev_stall[d] = 1'b0;
      end else begin
        chk($sformatf("in_ready_d%0d", d), {67'd0, m_irdy[d]}, {67'd0, !m_ov[d] || drv_ordy[d]});
        if (prev_stall[d]) begin
          chk($sformatf("stall_valid_d%0d", d), {67'd0, m_ov[d]}, 68'd1);
          chk($sformatf("stall_hold_d%0d", d), m_out[d], prev[d]);
        end else if (!m_ov[d]) begin
          chk($sformatf("idle_retain_d%0d", d), m_out[d], prev[d]);
        end
        if (m_ov[d] && drv_ordy[d]) begin
          chk($sformatf("unexpected_out_d%0d", d), {67'd0, head[d] != tail[d]}, 68'd1);
          if (head[d] != tail[d]) begin
            chk($sformatf("sb_result_d%0d", d), m_out[d], sb[d][head[d]]);
            head[d] = (head[d] + 1) % 64;
            n_out[d]++;
          end
        end
        if (drv_iv[d] && m_irdy[d]) begin
          sb[d][tail[d]] = model(WID[d], drv_a[d], drv_b[d], drv_sub[d]);
          tail[d] = (tail[d] + 1) % 64;
          n_in[d]++;
        end
        prev[d]       = m_out[d];
        prev_stall[d] = m_ov[d] && !drv_ordy[d];
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        s;
    logic [63:0] res;
    logic        co;
    logic        ov;
    logic        z;
    logic        n;
  } vec_t;

  initial begin
    vec_t tbl [7];
    int   lat, first, last, nov;
    int   burst [ND];

    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1, 1'b1, 1'b1, 1'b0};

    total = 0;
    bad   = 0;
    for (int d = 0; d < ND; d++) begin
      drv_iv[d] = 1'b0; drv_ordy[d] = 1'b1; drv_sub[d] = 1'b0;
      drv_a[d] = '0; drv_b[d] = '0;
      head[d] = 0; tail[d] = 0; n_in[d] = 0; n_out[d] = 0;
      prev[d] = '0; prev_stall[d] = 1'b0; burst[d] = 0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("reset_out_valid", {67'd0, m_ov[0]}, 68'd0);
    chk("reset_outputs", m_out[0], 68'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("post_reset_ready_d%0d", d), {67'd0, m_irdy[d]}, 68'd1);
      chk($sformatf("post_reset_valid_d%0d", d), {67'd0, m_ov[d]}, 68'd0);
    end

    // Directed vectors, one at a time, with latency measured from the accepting edge.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      drv_iv[0] = 1'b1; drv_a[0] = tbl[i].a; drv_b[0] = tbl[i].b; drv_sub[0] = tbl[i].s;
      @(posedge clk); #1;
      drv_iv[0] = 1'b0;
      lat = 1;
      while (!m_ov[0] && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("latency_vec%0d", i), 68'(lat), 68'd4);
      chk($sformatf("vec%0d", i), m_out[0], {tbl[i].res, tbl[i].co, tbl[i].ov, tbl[i].z, tbl[i].n});
    end
    repeat (6) @(posedge clk);

    // Eight back-to-back operations: results on eight consecutive cycles from edge 4.
    #1;
    first = -1; last = -1; nov = 0;
    for (int i = 0; i < 20; i++) begin
      if (i < 8) begin
        drv_iv[0] = 1'b1; drv_a[0] = {$urandom, $urandom}; drv_b[0] = {$urandom, $urandom};
        drv_sub[0] = ($urandom_range(0, 1) == 1);
      end else begin
        drv_iv[0] = 1'b0;
      end
      @(posedge clk); #1;
      if (m_ov[0]) begin
        if (first < 0) first = i + 1;
        last = i + 1;
        nov++;
      end
    end
    chk("b2b_first_edge", 68'(first), 68'd4);
    chk("b2b_count", 68'(nov), 68'd8);
    chk("b2b_span", 68'(last - first), 68'd7);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      drv_iv[0] = 1'b1; drv_a[0] = 64'h0123_4567_89AB_CDEF + 64'(i); drv_b[0] = 64'h1111; drv_sub[0] = 1'b0;
      @(posedge clk); #1;
    end
    drv_iv[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {67'd0, m_ov[0]}, 68'd0);
    chk("midrst_outputs", m_out[0], 68'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_after", {67'd0, m_irdy[0]}, 68'd1);
    nov = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (m_ov[0]) nov++;
    end
    chk("midrst_no_stale", 68'(nov), 68'd0);

    // Random traffic with output backpressure bursts on all three configurations.
    for (int d = 0; d < ND; d++) begin
      n_in[d] = 0;
      n_out[d] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int d = 0; d < ND; d++) begin
        drv_iv[d]  = ($urandom_range(0, 9) < 8);
        drv_a[d]   = pick();
        drv_b[d]   = pick();
        drv_sub[d] = ($urandom_range(0, 1) == 1);
        if (burst[d] > 0) begin
          drv_ordy[d] = 1'b0;
          burst[d]--;
        end else if ($urandom_range(0, 7) == 0) begin
          drv_ordy[d] = 1'b0;
          burst[d] = $urandom_range(0, 3);
        end else begin
          drv_ordy[d] = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < ND; d++) begin
      drv_iv[d] = 1'b0;
      drv_ordy[d] = 1'b1;
    end
    repeat (20) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("drain_count_d%0d", d), 68'(n_out[d]), 68'(n_in[d]));
      chk($sformatf("drain_empty_d%0d", d), 68'(tail[d]), 68'(head[d]));
    end
    chk("random_volume_ok", {67'd0, n_in[0] >= 1000}, 68'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
